ahbl_sram_slv: RTL and testbench

Parametrised AHB-Lite slave that fronts an internal word-addressed SRAM array on a multi-slave AHB-Lite bus. It generalises the bus-facing slave view in four ways: configurable data width, array depth, base address and programmable wait states. It decodes byte lanes from `hsize`/`haddr`, signals a two-cycle ERROR response for illegal transfers, and forwards pending write data to a back-to-back read. It sits behind the bus decoder, which drives `hsel` and `hready`.

---
 rtl/ahbl_sram_slv.sv | 101 ++++++++++
 tb/tb_ahbl_sram_slv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_slv.sv
// ahbl_sram_slv: AHB-Lite slave in front of a word-addressed SRAM array with byte lanes,
// programmable wait states, two-cycle ERROR responses and write-to-read forwarding.
module ahbl_sram_slv #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH * NB);
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic write_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [NB-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [31:0] off;
  logic [7:0] nbytes;
  logic done, take, commit, err_d;
  logic unused;
  assign unused = ^{htrans[0], hburst, hprot, hmastlock};
  assign off    = haddr - BASE_ADDR;
  assign nbytes = 8'd1 << hsize;
  assign idx_d  = off[LB +: AW];
  assign err_d  = (nbytes > 8'(NB)) || ((haddr & (32'(nbytes) - 32'd1)) != 32'd0) ||
                  (haddr < BASE_ADDR) || (33'(off) >= SPAN);
  assign done   = (state_q == IDLE) || (state_q == ERR2) || (state_q == DATA && wcnt_q == 3'd0);
  assign take   = hsel && hready && htrans[1] && done;
  assign commit = (state_q == DATA) && (wcnt_q == 3'd0) && write_q;
  assign hreadyout = !((state_q == ERR1) || (state_q == DATA && wcnt_q != 3'd0));
  assign hresp     = (state_q == ERR1) || (state_q == ERR2);
  assign hrdata    = rdata_q;
  always_comb begin
    mask_d = '0;
    for (int b = 0; b < NB; b++)
      mask_d[b] = (b >= int'(haddr[LB-1:0])) && (b < int'(haddr[LB-1:0]) + int'(nbytes));
  end
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (state_q == ERR1) state_d = ERR2;
    else if (!done) wcnt_d = wcnt_q - 3'd1;
    else begin
      state_d = !take ? IDLE : err_d ? ERR1 : DATA;
      wcnt_d  = (take && !err_d) ? 3'(WAIT_STATES) : 3'd0;
    end
  end
  // a read accepted on the edge a same-word write commits sees that write's bytes
  always_comb begin
    rdata_d = rdata_q;
    if (take && !hwrite && !err_d) begin
      rdata_d = mem[idx_d];
      for (int b = 0; b < NB; b++)
        if (commit && idx_q == idx_d && mask_q[b]) rdata_d[8*b +: 8] = hwdata[8*b +: 8];
    end
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      wcnt_q  <= 3'd0;
      rdata_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      if (take) begin
        write_q <= hwrite;
        idx_q   <= idx_d;
        mask_q  <= mask_d;
      end
    end
  end
  always_ff @(posedge hclk) begin
    if (commit)
      for (int b = 0; b < NB; b++)
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
  end
endmodule

// File: tb/tb_ahbl_sram_slv.sv
// tb_ahbl_sram_slv: two slaves (0 and 2 wait states) on one shared AHB-Lite bus, driven by a
// pipelined master and checked against a byte-addressed memory model.
module tb_ahbl_sram_slv;
  localparam logic [31:0] BASE = 32'h1000_0000;
  typedef struct {
    bit v, w, err, s2;
    logic [31:0] rd, wd;
    int off, nb;
  } ph_t;
  logic hclk = 0, hresetn = 0;
  logic hsel_b = 0, asel = 0, hwrite = 0, hmastlock = 0, dp_sel = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic [3:0] hprot = 0;
  logic [1:0] htrans = 0;
  logic ready0, ready2, resp0, resp2, hsel0, hsel2, hready, hresp_m;
  logic [31:0] rdata0, rdata2, hrdata_m;
  logic [7:0] mdl [2][256];
  logic [31:0] last_rd [2];
  int checks = 0, errors = 0, last_waits = 0;
  ph_t cur;
  assign hsel0    = hsel_b && !asel;
  assign hsel2    = hsel_b && asel;
  assign hready   = dp_sel ? ready2 : ready0;
  assign hresp_m  = dp_sel ? resp2 : resp0;
  assign hrdata_m = dp_sel ? rdata2 : rdata0;
  always #5 hclk = ~hclk;
  ahbl_sram_slv #(.WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .htrans(htrans), .hwdata(hwdata),
    .hready(hready), .hreadyout(ready0), .hresp(resp0), .hrdata(rdata0));
  ahbl_sram_slv #(.WAIT_STATES(2)) u2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .htrans(htrans), .hwdata(hwdata),
    .hready(hready), .hreadyout(ready2), .hresp(resp2), .hrdata(rdata2));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mword(int s, int off);
    int w = off & ~3;
    return {mdl[s][w+3], mdl[s][w+2], mdl[s][w+1], mdl[s][w]};
  endfunction
  function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
    longint nb = longint'(1) << sz;
    longint la = longint'(a);
    return nb > 4 || (la % nb) != 0 || la < longint'(BASE) || la >= longint'(BASE) + 1024;
  endfunction
  // one bus cycle group: drive the next address phase plus the current data, wait out the
  // current data phase, check its response, then let the edge accept the new address phase
  task automatic step(bit hs, logic [1:0] ht, bit s2, bit w, logic [31:0] a, logic [2:0] sz,
                      logic [31:0] wd);
    int waits = 0;
    ph_t nx;
    @(negedge hclk);
    dp_sel = cur.s2;
    hsel_b = hs; asel = s2; htrans = ht; haddr = a; hwrite = w; hsize = sz; hwdata = cur.wd;
    #1;
    while (!hready && waits < 20) begin
      if (cur.v && cur.err && waits == 0) chk("err1_resp", hresp_m, 1);
      waits++;
      @(negedge hclk);
      #1;
    end
    last_waits = waits;
    if (cur.v) begin
      chk("waits", waits, cur.err ? 1 : (cur.s2 ? 2 : 0));
      chk("resp", hresp_m, cur.err);
      chk("rdata", hrdata_m, cur.rd);
      if (cur.w && !cur.err)
        for (int i = 0; i < cur.nb; i++) mdl[cur.s2][cur.off+i] = cur.wd[8*((cur.off+i)%4) +: 8];
    end else chk("idle_ok", {30'd0, hready, hresp_m}, 32'd2);
    @(posedge hclk);
    nx.v = hs && ht[1]; nx.s2 = s2; nx.w = w; nx.err = is_err(a, sz); nx.wd = wd;
    nx.nb = 1 << sz; nx.off = int'(a - BASE);
    if (nx.v && !w && !nx.err) last_rd[s2] = mword(s2, nx.off);
    nx.rd = last_rd[s2];
    cur = nx;
  endtask
  task automatic wr(bit s2, logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    step(1, 2'b10, s2, 1, a, sz, d);
  endtask
  task automatic rd(bit s2, logic [31:0] a, logic [2:0] sz);
    step(1, 2'b10, s2, 0, a, sz, 0);
  endtask
  task automatic idle();
    step(1, 2'b00, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bit s2, w;
    int r, off;
    logic [2:0] sz;
    logic [31:0] a;
    cur = '{default: 0};
    last_rd[0] = 0;
    last_rd[1] = 0;
    repeat (3) @(negedge hclk);
    chk("rst_ready0", ready0, 1); chk("rst_resp0", resp0, 0); chk("rst_rdata0", rdata0, 0);
    hresetn = 1;
    @(negedge hclk);
    chk("post_ready0", ready0, 1); chk("post_resp0", resp0, 0); chk("post_rdata0", rdata0, 0);
    chk("post_ready2", ready2, 1); chk("post_resp2", resp2, 0); chk("post_rdata2", rdata2, 0);
    for (int i = 0; i < 64; i++) begin
      wr(0, BASE + 32'(4*i), 2, $urandom);
      wr(1, BASE + 32'(4*i), 2, $urandom);
    end
    idle();
    wr(0, BASE + 32'h10, 2, 32'hDEADBEEF);
    wr(0, BASE + 32'h12, 0, 32'h005A_0000);
    rd(0, BASE + 32'h10, 2);
    idle();
    @(negedge hclk);
    chk("word_byte", rdata0, 32'hDE5ABEEF);
    chk("word_byte_waits", last_waits, 0);
    rd(1, BASE, 2);
    idle();
    chk("ws2_waits", last_waits, 2);
    rd(0, BASE + 32'h400, 2);
    idle();
    chk("oor_waits", last_waits, 1);
    wr(0, BASE + 32'h1, 1, 32'hFFFF_FFFF);
    rd(0, BASE, 2);
    idle();
    rd(0, BASE, 3);
    idle();
    chk("oversize_waits", last_waits, 1);
    wr(0, BASE + 32'h20, 2, 32'h1122_3344);
    rd(0, BASE + 32'h20, 2);
    idle();
    @(negedge hclk);
    chk("fwd", rdata0, 32'h1122_3344);
    wr(1, BASE + 32'h24, 2, 32'hA5A5_0F0F);
    rd(1, BASE + 32'h24, 2);
    step(0, 2'b10, 0, 1, BASE, 2, 32'hFFFF_FFFF);
    step(1, 2'b01, 1, 1, BASE, 2, 32'hFFFF_FFFF);
    rd(0, BASE, 2);
    idle();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      s2 = ($urandom_range(0, 3) == 0);
      w = 1'($urandom_range(0, 1));
      if (r < 70) begin
        sz = 3'($urandom_range(0, 2));
        off = $urandom_range(0, 255) & ~((1 << sz) - 1);
        step(1, 2'b10 | 2'($urandom_range(0, 1)), s2, w, BASE + 32'(off), sz, $urandom);
      end else if (r < 80) begin
        if ($urandom_range(0, 1) == 0) step(0, 2'b10, s2, w, BASE, 2, $urandom);
        else step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), s2, w, BASE, 2, $urandom);
      end else if (r < 87) begin
        a = ($urandom_range(0, 1) == 1) ? BASE + 32'h400 + 32'(4*$urandom_range(0, 255))
                                        : BASE - 32'(4*$urandom_range(1, 64));
        step(1, 2'b10, s2, w, a, 2, $urandom);
      end else if (r < 94) begin
        sz = 3'($urandom_range(1, 2));
        a = BASE + 32'(($urandom_range(0, 63) * 4) | ((sz == 1) ? 1 : $urandom_range(1, 3)));
        step(1, 2'b10, s2, w, a, sz, $urandom);
      end else step(1, 2'b10, s2, w, BASE, 3'($urandom_range(3, 7)), $urandom);
    end
    idle();
    wr(1, BASE + 32'h40, 2, 32'hCAFE_F00D);
    @(negedge hclk);
    hwdata = cur.wd; htrans = 2'b00; asel = 0; dp_sel = 1;
    #1;
    chk("abort_wait", ready2, 0);
    hresetn = 0;
    #1;
    chk("abort_ready", ready2, 1); chk("abort_resp", resp2, 0); chk("abort_rdata", rdata2, 0);
    @(negedge hclk);
    hresetn = 1;
    cur = '{default: 0};
    last_rd[0] = 0;
    last_rd[1] = 0;
    rd(1, BASE + 32'h40, 2);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
